// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store controller: access sizes, FSM states
// and the default data-memory depth.
package lsu_pkg;

  localparam int MEM_WORDS_DEF = 512;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    DONE = 2'b11
  } state_t;

endpackage

// File: rtl/lsu_lane.sv
// Little-endian lane logic: extracts and extends the addressed byte/halfword
// of a memory word, and merges store data into the addressed lane.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] wdata_rep;
  logic [3:0]  be;

  always_comb begin
    byte_v    = word[{lane, 3'b000} +: 8];
    half_v    = word[{lane[1], 4'b0000} +: 16];
    load_val  = word;
    wdata_rep = wdata;
    case (size)
      SZ_BYTE: begin
        load_val  = {{24{byte_v[7] & ~uns}}, byte_v};
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        load_val  = {{16{half_v[15] & ~uns}}, half_v};
        wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        load_val  = word;
        wdata_rep = wdata;
      end
    endcase
  end

  // Store data is replicated across lanes; the byte enables pick which lanes replace the old word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign be[gi] = (size == SZ_BYTE) ? (lane == 2'(gi)) :
                    (size == SZ_HALF) ? (lane[1] == 1'(gi / 2)) : 1'b1;
    assign store_word[8*gi +: 8] = be[gi] ? wdata_rep[8*gi +: 8] : word[8*gi +: 8];
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store controller: validates a request, reads the target
// word, performs read-modify-write for sub-word stores and extends loads.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              MemR,
  output logic              MemWr,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [ADDR_W-3:0] WORD_LIMIT = (ADDR_W-2)'(MEM_WORDS);

  state_t            state_reg, state_next;
  logic              we_reg, uns_reg, err_reg;
  logic [1:0]        size_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg, word_reg, rdata_reg;
  logic              illegal;
  logic [31:0]       lane_word, load_val, store_word;
  logic [ADDR_W-1:0] aligned_addr;

  always_comb begin
    illegal = 1'b0;
    case (size)
      SZ_BYTE: illegal = 1'b0;
      SZ_HALF: illegal = addr[0];
      SZ_WORD: illegal = |addr[1:0];
      default: illegal = 1'b1;
    endcase
    if (addr[ADDR_W-1:2] >= WORD_LIMIT) illegal = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    MemR       = 1'b0;
    MemWr      = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (req) begin
          if (illegal)                      state_next = DONE;
          else if (we && size == SZ_WORD)   state_next = WR;
          else                              state_next = RD;
        end
      end
      RD: begin
        MemR       = 1'b1;
        state_next = we_reg ? WR : DONE;
      end
      WR: begin
        MemWr      = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        err        = err_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The load result is registered on leaving RD so it is already valid during DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_reg    <= 1'b0;
      uns_reg   <= 1'b0;
      err_reg   <= 1'b0;
      size_reg  <= 2'b00;
      addr_reg  <= '0;
      wdata_reg <= '0;
      word_reg  <= '0;
      rdata_reg <= '0;
    end else begin
      if (state_reg == IDLE && req) begin
        we_reg    <= we;
        uns_reg   <= uns;
        size_reg  <= size;
        addr_reg  <= addr;
        wdata_reg <= wdata;
        err_reg   <= illegal;
      end
      if (state_reg == RD) begin
        word_reg <= mem_rdata;
        if (!we_reg) rdata_reg <= load_val;
      end
    end
  end

  assign lane_word    = (state_reg == RD) ? mem_rdata : word_reg;
  assign aligned_addr = {addr_reg[ADDR_W-1:2], 2'b00};

  lsu_lane u_lane (
    .word       (lane_word),
    .lane       (addr_reg[1:0]),
    .size       (size_reg),
    .uns        (uns_reg),
    .wdata      (wdata_reg),
    .load_val   (load_val),
    .store_word (store_word)
  );

  assign rdata     = rdata_reg;
  assign mem_addr  = (state_reg == RD || state_reg == WR) ? 32'(aligned_addr) : 32'd0;
  assign mem_wdata = (state_reg == WR) ? store_word : 32'd0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: stimulus queues expected completions and
// memory accesses; a negedge monitor pops and compares them as they appear.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, err, MemR, MemWr;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  lsu_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .MemR(MemR), .MemWr(MemWr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:511];
  assign mem_rdata = mem[mem_addr[10:2]];
  always @(posedge clk) if (MemWr) mem[mem_addr[10:2]] <= mem_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int req_cyc; int lat; logic err; logic [31:0] rdata; int id;} done_exp_t;
  typedef struct {int cyc; logic [31:0] addr; logic [31:0] data;} acc_exp_t;

  done_exp_t   dq[$];
  acc_exp_t    rq[$];
  acc_exp_t    wq[$];
  int          checks = 0;
  int          errors = 0;
  int          txn_id = 0;
  logic [31:0] hold = '0;
  logic        done_prev = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    done_exp_t de;
    acc_exp_t  ae;
    if (!rst) begin
      check32("memr_memwr_exclusive", 32'(MemR & MemWr), 32'd0);
      if (done && done_prev) check32("done_width", 32'd2, 32'd1);
      if (done) begin
        if (dq.size() == 0) check32("unexpected_done", 32'd1, 32'd0);
        else begin
          de = dq.pop_front();
          check32($sformatf("txn%0d_err", de.id), 32'(err), 32'(de.err));
          check32($sformatf("txn%0d_rdata", de.id), rdata, de.rdata);
          check32($sformatf("txn%0d_latency", de.id), 32'(cyc - de.req_cyc), 32'(de.lat));
          $display("TXN %0d done err=%0b rdata=%h latency=%0d", de.id, err, rdata, cyc - de.req_cyc);
        end
      end
      if (MemR) begin
        if (rq.size() == 0) check32("unexpected_memr", mem_addr, 32'hFFFF_FFFF);
        else begin
          ae = rq.pop_front();
          check32("memr_addr", mem_addr, ae.addr);
          check32("memr_cycle", 32'(cyc), 32'(ae.cyc));
        end
      end
      if (MemWr) begin
        if (wq.size() == 0) check32("unexpected_memwr", mem_addr, 32'hFFFF_FFFF);
        else begin
          ae = wq.pop_front();
          check32("memwr_addr", mem_addr, ae.addr);
          check32("memwr_data", mem_wdata, ae.data);
          check32("memwr_cycle", 32'(cyc), 32'(ae.cyc));
        end
      end
      done_prev = done;
    end
  end

  task automatic drain();
    int n = 0;
    while ((dq.size() != 0 || rq.size() != 0 || wq.size() != 0) && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      check32("drain_timeout", 32'(dq.size() + rq.size() + wq.size()), 32'd0);
      dq.delete(); rq.delete(); wq.delete();
    end
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                       input logic [31:0] d, input logic e, input logic [31:0] exp_rd, input int lat,
                       input logic has_rd, input logic has_wr, input int wr_off, input logic [31:0] wr_data);
    @(negedge clk);
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
    txn_id++;
    dq.push_back('{cyc, lat, e, exp_rd, txn_id});
    if (has_rd) rq.push_back('{cyc + 1, {a[31:2], 2'b00}, 32'd0});
    if (has_wr) wq.push_back('{cyc + wr_off, {a[31:2], 2'b00}, wr_data});
    @(negedge clk);
    req = 1'b0;
    drain();
  endtask

  task automatic load(input logic [1:0] sz, input logic u, input logic [31:0] a, input logic [31:0] exp_v);
    hold = exp_v;
    issue(1'b0, sz, u, a, 32'd0, 1'b0, exp_v, 2, 1'b1, 1'b0, 0, 32'd0);
  endtask

  task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d, input logic [31:0] merged);
    if (sz == SZ_WORD) issue(1'b1, sz, 1'b0, a, d, 1'b0, hold, 2, 1'b0, 1'b1, 1, merged);
    else               issue(1'b1, sz, 1'b0, a, d, 1'b0, hold, 3, 1'b1, 1'b1, 2, merged);
  endtask

  task automatic bad(input logic w, input logic [1:0] sz, input logic [31:0] a);
    issue(w, sz, 1'b0, a, 32'hA5A5_A5A5, 1'b1, hold, 1, 1'b0, 1'b0, 0, 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check32({tag, "_busy"}, 32'(busy), 32'd0);
    check32({tag, "_done"}, 32'(done), 32'd0);
    check32({tag, "_err"}, 32'(err), 32'd0);
    check32({tag, "_memr"}, 32'(MemR), 32'd0);
    check32({tag, "_memwr"}, 32'(MemWr), 32'd0);
    check32({tag, "_rdata"}, rdata, 32'd0);
    check32({tag, "_mem_addr"}, mem_addr, 32'd0);
    check32({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    int c;
    for (int i = 0; i < 512; i++) mem[i] = 32'd0;
    mem[32'h20 >> 2] = 32'h80FF7F01;
    mem[32'h30 >> 2] = 32'h11223344;
    mem[32'h50 >> 2] = 32'h55667788;

    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    store(SZ_WORD, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF);
    load(SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF);

    load(SZ_BYTE, 1'b0, 32'h23, 32'hFFFFFF80);
    load(SZ_BYTE, 1'b1, 32'h23, 32'h00000080);
    load(SZ_BYTE, 1'b0, 32'h21, 32'h0000007F);
    load(SZ_HALF, 1'b0, 32'h22, 32'hFFFF80FF);
    load(SZ_HALF, 1'b1, 32'h22, 32'h000080FF);
    load(SZ_BYTE, 1'b1, 32'h20, 32'h00000001);
    load(SZ_BYTE, 1'b0, 32'h22, 32'hFFFFFFFF);
    load(SZ_HALF, 1'b0, 32'h20, 32'h00007F01);
    load(SZ_WORD, 1'b1, 32'h20, 32'h80FF7F01);

    store(SZ_BYTE, 32'h31, 32'h000000AB, 32'h1122AB44);
    store(SZ_HALF, 32'h32, 32'h0000CDEF, 32'hCDEFAB44);
    load(SZ_WORD, 1'b0, 32'h30, 32'hCDEFAB44);

    store(SZ_WORD, 32'h7FC, 32'h12345678, 32'h12345678);
    load(SZ_HALF, 1'b1, 32'h7FE, 32'h00001234);

    bad(1'b0, SZ_HALF, 32'h41);
    bad(1'b0, SZ_WORD, 32'h42);
    bad(1'b0, 2'b11, 32'h40);
    bad(1'b0, SZ_WORD, 32'h800);
    bad(1'b1, SZ_BYTE, 32'h800);
    bad(1'b1, SZ_WORD, 32'h42);

    // Continuous req across a load: second acceptance only after DONE.
    @(negedge clk);
    c = cyc;
    req = 1'b1; we = 1'b0; size = SZ_WORD; uns = 1'b0; addr = 32'h10; wdata = 32'd0;
    hold = 32'hDEADBEEF;
    txn_id++; dq.push_back('{c, 2, 1'b0, 32'hDEADBEEF, txn_id});
    txn_id++; dq.push_back('{c + 3, 2, 1'b0, 32'hDEADBEEF, txn_id});
    rq.push_back('{c + 1, 32'h10, 32'd0});
    rq.push_back('{c + 4, 32'h10, 32'd0});
    repeat (4) @(negedge clk);
    req = 1'b0;
    drain();

    // Reset during the write cycle of a byte store.
    @(negedge clk);
    c = cyc;
    req = 1'b1; we = 1'b1; size = SZ_BYTE; uns = 1'b0; addr = 32'h51; wdata = 32'h000000EE;
    rq.push_back('{c + 1, 32'h50, 32'd0});
    wq.push_back('{c + 2, 32'h50, 32'h5566EE88});
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    #2;
    check32("abort_memwr_before", 32'(MemWr), 32'd1);
    rst = 1'b1;
    #1;
    check32("abort_memwr_after", 32'(MemWr), 32'd0);
    check32("abort_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    done_prev = 1'b0;
    hold = 32'd0;
    #1;
    check_idle_outputs("post_abort");
    check32("abort_mem_unchanged", mem[32'h50 >> 2], 32'h55667788);
    repeat (3) @(negedge clk);
    load(SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
